mem_arbiter: RTL

Two-requester arbiter that shares the processor's single-port main memory between the instruction-fetch path and the data path (load/store, stack push/pop, return-address reads). The multicycle control unit's fetch and data memory strobes connect as requesters. The arbiter serialises accesses, drives the memory port, and returns registered read data with a one-cycle done pulse.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter serialising fetch and data accesses onto one memory port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT=%0d is outside the legal range 1..4", MEM_LAT);
  end

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              win_data;

  // gnt/last encode the owner as 1 = data path, 0 = fetch path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    win_data    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_io.if_req || bus_io.d_req) begin
`ifdef MEM_ARB_RR_EN
          // On a tie the requester that did not own the previous transaction wins
          win_data = bus_io.d_req && (!bus_io.if_req || !last_q);
`else
          win_data = bus_io.d_req;
`endif
          gnt_d      = win_data;
          wr_d       = win_data && bus_io.d_we;
          mem_en_d   = 1'b1;
          mem_we_d   = win_data && bus_io.d_we;
          mem_addr_d = win_data ? bus_io.d_addr : bus_io.if_addr;
          if (win_data) begin
            mem_wdata_d = bus_io.d_wdata;
          end
          cnt_d   = 3'd1;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (wr_q) begin
          d_done_d = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == LAT) begin
          // Only the sample at the end of the last latency cycle is valid read data
          if (gnt_q) begin
            d_rdata_d = bus_io.mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            if_rdata_d = bus_io.mem_rdata;
            if_done_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_io.mem_en    = mem_en_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.d_rdata   = d_rdata_q;
  assign bus_io.if_done   = if_done_q;
  assign bus_io.d_done    = d_done_q;
  assign bus_io.busy      = (state_q != IDLE);

endmodule
